// File: rtl/sr_pkg.sv
// Shared types and constants for the SR command sequencer.
//   state_t : sequencer FSM states (IDLE, DRIVE, GAP)
//   cmd_t   : resolved command (CMD_SET drives s, CMD_CLR drives r)
//   CNT_W   : width of the hold/gap counter and the conflict counter
package sr_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  typedef enum logic {
    CMD_SET,
    CMD_CLR
  } cmd_t;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit saturating incrementer.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears count
//   inc   - increment request for this cycle
//   count - current value, sticks at all-ones
module sat_counter8
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: clocked state is written with non-blocking (<=) assignments so every
  // register samples pre-edge values; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command front-end for a negedge-sampled SR flip-flop. Accepts set/clear
// requests while idle, resolves collisions, drives s or r for HOLD_CYCLES,
// then idles for GAP_CYCLES. A shadow of the flip-flop state allows
// redundant commands to complete without driving.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   set_req, clr_req  - requests, sampled on posedge while idle
//   s, r              - registered drives to the flip-flop (never both high)
//   busy              - high in DRIVE and GAP
//   done              - one-cycle pulse when a command completes
//   req_drop          - one-cycle pulse when a request arrives while busy
//   q_shadow          - expected flip-flop state
//   shadow_vld        - q_shadow is meaningful
//   conflict_cnt      - saturating count of simultaneous set/clear requests
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2,  // 1..255
  parameter int GAP_CYCLES     = 1,  // 0..255
  parameter int SET_PRIORITY   = 1,  // 1: set wins a collision, 0: clear wins
  parameter int SKIP_REDUNDANT = 1   // 1: skip commands matching a valid shadow
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       req_drop,
  output logic       q_shadow,
  output logic       shadow_vld,
  output logic [7:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             shadow_q, shadow_d;
  logic             vld_q, vld_d;
  logic             req_any;
  logic             conflict;
  cmd_t             cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      shadow_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      shadow_q <= shadow_d;
      vld_q    <= vld_d;
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    r_d      = r_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    shadow_d = shadow_q;
    vld_d    = vld_q;
    conflict = 1'b0;
    req_any  = set_req | clr_req;

    // Collision resolution; a lone request is served as-is.
    if (set_req && clr_req) begin
      cmd = (SET_PRIORITY != 0) ? CMD_SET : CMD_CLR;
    end else if (set_req) begin
      cmd = CMD_SET;
    end else begin
      cmd = CMD_CLR;
    end

    case (state_q)
      IDLE: begin
        if (req_any) begin
          conflict = set_req & clr_req;
          if ((SKIP_REDUNDANT != 0) && vld_q &&
              (shadow_q == (cmd == CMD_SET))) begin
            done_d = 1'b1;
          end else begin
            state_d = DRIVE;
            cnt_d   = HOLD_LOAD;
            // s_d and r_d come from one cmd value, so they are exclusive.
            s_d     = (cmd == CMD_SET);
            r_d     = (cmd == CMD_CLR);
          end
        end
      end

      DRIVE: begin
        drop_d = req_any;
        if (cnt_q == '0) begin
          s_d      = 1'b0;
          r_d      = 1'b0;
          shadow_d = s_q;  // s high means the command was a set
          vld_d    = 1'b1;
          done_d   = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      GAP: begin
        drop_d = req_any;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  sat_counter8 u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (conflict),
    .count (conflict_cnt)
  );

  assign s          = s_q;
  assign r          = r_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign req_drop   = drop_q;
  assign q_shadow   = shadow_q;
  assign shadow_vld = vld_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer. Instance a uses the default
// parameters (HOLD=2, GAP=1, set priority, skip redundant); instance b uses
// HOLD=2, GAP=0, clear priority, no skipping. Stimulus pushes expected
// done/drop events; a negedge monitor pops and compares them.
module tb_sr_cmd_sequencer;

  typedef enum logic {EV_DONE, EV_DROP} ev_t;

  typedef struct {
    int         inst;
    ev_t        kind;
    int         cyc;
    int         s_n;
    int         r_n;
    logic       q;
    logic [7:0] cnt;
  } exp_t;

  localparam int M_NONE = 0;
  localparam int M_DONE = 1;
  localparam int M_DROP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic set_a = 1'b0, clr_a = 1'b0, set_b = 1'b0, clr_b = 1'b0;

  logic       s_a, r_a, busy_a, done_a, drop_a, q_a, vld_a;
  logic       s_b, r_b, busy_b, done_b, drop_b, q_b, vld_b;
  logic [7:0] cnt_a, cnt_b;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   s_run[2];
  int   r_run[2];

  sr_cmd_sequencer #(
    .HOLD_CYCLES(2), .GAP_CYCLES(1), .SET_PRIORITY(1), .SKIP_REDUNDANT(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .set_req(set_a), .clr_req(clr_a),
    .s(s_a), .r(r_a), .busy(busy_a), .done(done_a), .req_drop(drop_a),
    .q_shadow(q_a), .shadow_vld(vld_a), .conflict_cnt(cnt_a)
  );

  sr_cmd_sequencer #(
    .HOLD_CYCLES(2), .GAP_CYCLES(0), .SET_PRIORITY(0), .SKIP_REDUNDANT(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .set_req(set_b), .clr_req(clr_b),
    .s(s_b), .r(r_b), .busy(busy_b), .done(done_b), .req_drop(drop_b),
    .q_shadow(q_b), .shadow_vld(vld_b), .conflict_cnt(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find(input int inst, input ev_t kind);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].inst == inst && sb[i].kind == kind) return i;
    end
    return -1;
  endfunction

  task automatic observe(input int inst, input logic s, input logic r,
                         input logic done, input logic drop, input logic q,
                         input logic vld, input logic [7:0] cnt);
    int   idx;
    exp_t e;
    if (s && r) begin
      miscompares++;
      $display("FAIL s_r_overlap inst%0d: s=1 r=1, required never both", inst);
    end
    if (s) s_run[inst]++;
    if (r) r_run[inst]++;
    if (done === 1'b1) begin
      idx = find(inst, EV_DONE);
      if (idx < 0) begin
        miscompares++;
        $display("FAIL unexpected_done inst%0d: done=1 at cycle %0d, required 0",
                 inst, cyc);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        check($sformatf("done_cycle_i%0d", inst), cyc, e.cyc);
        check($sformatf("s_cycles_i%0d", inst), s_run[inst], e.s_n);
        check($sformatf("r_cycles_i%0d", inst), r_run[inst], e.r_n);
        check($sformatf("q_shadow_i%0d", inst), {31'd0, q}, {31'd0, e.q});
        check($sformatf("shadow_vld_i%0d", inst), {31'd0, vld}, 32'd1);
        check($sformatf("conflict_cnt_i%0d", inst), {24'd0, cnt}, {24'd0, e.cnt});
      end
      s_run[inst] = 0;
      r_run[inst] = 0;
    end
    if (drop === 1'b1) begin
      idx = find(inst, EV_DROP);
      if (idx < 0) begin
        miscompares++;
        $display("FAIL unexpected_drop inst%0d: req_drop=1 at cycle %0d, required 0",
                 inst, cyc);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        check($sformatf("drop_cycle_i%0d", inst), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        s_run[i] = 0;
        r_run[i] = 0;
      end
    end else begin
      observe(0, s_a, r_a, done_a, drop_a, q_a, vld_a, cnt_a);
      observe(1, s_b, r_b, done_b, drop_b, q_b, vld_b, cnt_b);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: drives the request for the next posedge, records the
  // expected event relative to that sampling edge, then releases the request.
  task automatic send(input int inst, input logic sr, input logic cr,
                      input int mode, input int lat, input int sn, input int rn,
                      input logic q, input logic [7:0] cnt);
    exp_t e;
    if (inst == 0) begin set_a = sr; clr_a = cr; end
    else           begin set_b = sr; clr_b = cr; end
    if (mode != M_NONE) begin
      e.inst = inst;
      e.kind = (mode == M_DROP) ? EV_DROP : EV_DONE;
      e.cyc  = cyc + 1 + lat;
      e.s_n  = sn;
      e.r_n  = rn;
      e.q    = q;
      e.cnt  = cnt;
      sb.push_back(e);
    end
    @(negedge clk);
    if (inst == 0) begin set_a = 1'b0; clr_a = 1'b0; end
    else           begin set_b = 1'b0; clr_b = 1'b0; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_s_a", {31'd0, s_a}, 32'd0);
    check("rst_r_a", {31'd0, r_a}, 32'd0);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_drop_a", {31'd0, drop_a}, 32'd0);
    check("rst_q_a", {31'd0, q_a}, 32'd0);
    check("rst_vld_a", {31'd0, vld_a}, 32'd0);
    check("rst_cnt_a", {24'd0, cnt_a}, 32'd0);
    check("rst_s_b", {31'd0, s_b}, 32'd0);
    check("rst_r_b", {31'd0, r_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Instance a: plain set, 2-cycle drive, 1-cycle gap.
    send(0, 1'b1, 1'b0, M_DONE, 2, 2, 0, 1'b1, 8'd0);
    idle(2);
    check("busy_in_gap_a", {31'd0, busy_a}, 32'd1);
    idle(1);
    check("busy_after_gap_a", {31'd0, busy_a}, 32'd0);

    // Redundant set is skipped: done next cycle, no drive, never busy.
    send(0, 1'b1, 1'b0, M_DONE, 0, 0, 0, 1'b1, 8'd0);
    check("busy_on_skip_a", {31'd0, busy_a}, 32'd0);
    idle(1);

    // Collision, set wins, also redundant: skipped but counted.
    send(0, 1'b1, 1'b1, M_DONE, 0, 0, 0, 1'b1, 8'd1);
    idle(1);

    // Clear drives r.
    send(0, 1'b0, 1'b1, M_DONE, 2, 0, 2, 1'b0, 8'd1);
    idle(3);

    // Set, then a clear during DRIVE is dropped; the set completes unchanged.
    send(0, 1'b1, 1'b0, M_DONE, 2, 2, 0, 1'b1, 8'd1);
    send(0, 1'b0, 1'b1, M_DROP, 0, 0, 0, 1'b0, 8'd0);
    idle(3);

    // Clear, then a set arriving in GAP is dropped.
    send(0, 1'b0, 1'b1, M_DONE, 2, 0, 2, 1'b0, 8'd1);
    idle(2);
    send(0, 1'b1, 1'b0, M_DROP, 0, 0, 0, 1'b0, 8'd0);
    idle(3);

    // Instance b: collision, clear wins.
    send(1, 1'b1, 1'b1, M_DONE, 2, 0, 2, 1'b0, 8'd1);
    idle(2);
    // Set twice: no skipping, both fully driven.
    send(1, 1'b1, 1'b0, M_DONE, 2, 2, 0, 1'b1, 8'd1);
    idle(2);
    send(1, 1'b1, 1'b0, M_DONE, 2, 2, 0, 1'b1, 8'd1);
    idle(2);
    // Clear at the earliest acceptance point after the set (no gap state).
    send(1, 1'b0, 1'b1, M_DONE, 2, 0, 2, 1'b0, 8'd1);
    idle(2);

    // 300 collisions: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      send(1, 1'b1, 1'b1, M_DONE, 2, 0, 2, 1'b0,
           ((2 + i) > 255) ? 8'd255 : 8'(2 + i));
      idle(2);
    end
    check("conflict_saturated_b", {24'd0, cnt_b}, 32'd255);

    // Reset in the middle of a drive on a: outputs drop without a clock edge.
    send(0, 1'b1, 1'b0, M_NONE, 0, 0, 0, 1'b0, 8'd0);
    check("s_before_reset_a", {31'd0, s_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s_a", {31'd0, s_a}, 32'd0);
    check("async_rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("async_rst_vld_a", {31'd0, vld_a}, 32'd0);
    check("async_rst_done_a", {31'd0, done_a}, 32'd0);
    check("async_rst_cnt_b", {24'd0, cnt_b}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset the shadow is invalid, so a set is driven normally.
    send(0, 1'b1, 1'b0, M_DONE, 2, 2, 0, 1'b1, 8'd0);
    idle(5);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
